dreg_bank: RTL

DREG_BANK -- requirements
Module: dreg_bank

---
 rtl/dreg_pkg.sv | 13 +
 rtl/dreg_cell.sv | 55 +++++
 rtl/dreg_bank.sv | 83 ++++++++
 3 files changed

// File: rtl/dreg_pkg.sv
// Shared types and constants for the dreg_bank channel register file.
package dreg_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        LOAD = 2'b01,
        SHL  = 2'b10,
        SHR  = 2'b11
    } mode_e;

    localparam int OP_CNT_W = 8;

endpackage

// File: rtl/dreg_cell.sv
// One WIDTH-bit channel register with load/shift next-value logic and async clear.
module dreg_cell
    import dreg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             en,
    input  mode_e            mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] val,
    output logic             diff
);

    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;
    logic [WIDTH-1:0] nxt;

    // A single-bit register has nothing to keep on a shift; sin replaces it
    generate
        if (WIDTH == 1) begin : g_w1
            assign shl = sin;
            assign shr = sin;
        end else begin : g_wn
            assign shl = {val[WIDTH-2:0], sin};
            assign shr = {sin, val[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        nxt = val;
        if (en) begin
            case (mode)
                HOLD:    nxt = val;
                LOAD:    nxt = d;
                SHL:     nxt = shl;
                SHR:     nxt = shr;
                default: nxt = val;
            endcase
        end
    end

    assign diff = (nxt != val);

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            val <= '0;
        end else begin
            val <= nxt;
        end
    end

endmodule

// File: rtl/dreg_bank.sv
// Bank of CHANNELS shift/load registers with selected-channel readout.
// Define DREG_PARITY_EN to add the combinational parity output.
module dreg_bank
    import dreg_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rest,
    input  logic [1:0]          mode,
    input  logic [SEL_W-1:0]    ch_sel,
    input  logic [WIDTH-1:0]    d,
    input  logic                sin,
    output logic [WIDTH-1:0]    q,
    output logic [WIDTH-1:0]    qpar,
    output logic                changed,
    output logic                sel_err,
    output logic [OP_CNT_W-1:0] op_cnt
`ifdef DREG_PARITY_EN
    ,
    output logic                parity
`endif
);

    logic [WIDTH-1:0]    vals [CHANNELS];
    logic [CHANNELS-1:0] hit;
    logic [CHANNELS-1:0] diff;
    logic                valid;
    logic                active;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            assign hit[i] = (ch_sel == SEL_W'(i));

            dreg_cell #(
                .WIDTH(WIDTH)
            ) u_cell (
                .clk (clk),
                .rest(rest),
                .en  (hit[i]),
                .mode(mode_e'(mode)),
                .d   (d),
                .sin (sin),
                .val (vals[i]),
                .diff(diff[i])
            );
        end
    endgenerate

    // Out-of-range selects match no channel, so q falls back to zero
    assign valid  = |hit;
    assign active = (mode_e'(mode) != HOLD);

    always_comb begin
        q = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (hit[i]) q = vals[i];
        end
    end

    assign qpar = ~q;

`ifdef DREG_PARITY_EN
    assign parity = ^q;
`endif

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            changed <= 1'b0;
            sel_err <= 1'b0;
            op_cnt  <= '0;
        end else begin
            changed <= |diff;
            sel_err <= active && !valid;
            if (active && valid && (op_cnt != {OP_CNT_W{1'b1}})) begin
                op_cnt <= op_cnt + 1'b1;
            end
        end
    end

endmodule
